// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one radix-2 step per cycle, fixed 34-cycle latency.
// Results land in hi/lo after a sign-fix cycle; div_by_zero flags the last divide by zero.
module mul_div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] port_A,
    input  logic [31:0] port_B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] mag_b;
    logic [31:0] acc_hi, acc_lo;

    logic        accept;
    logic [31:0] mag_a_in, mag_b_in;
    logic [31:0] step_hi, step_lo;
    logic [32:0] sum, shifted;
    logic [33:0] diff;
    logic [63:0] prod;
    logic        sign_a, sign_b;
    logic [31:0] fix_hi, fix_lo;
    logic        fix_dbz;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);

    // op[0]==0 selects the signed variants; iterate on magnitudes only
    assign mag_a_in = (!op[0] && port_A[31]) ? -port_A : port_A;
    assign mag_b_in = (!op[0] && port_B[31]) ? -port_B : port_B;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared accumulator: multiply shifts the product right through {acc_hi,acc_lo};
    // divide shifts the dividend left out of acc_lo into the remainder in acc_hi.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);
        shifted = {acc_hi, acc_lo[31]};
        diff    = {1'b0, shifted} - {2'b00, mag_b};
        step_hi = sum[32:1];
        step_lo = {sum[0], acc_lo[31:1]};
        if (op_r[1]) begin
            if (diff[33]) begin
                step_hi = shifted[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end else begin
                step_hi = diff[31:0];
                step_lo = {acc_lo[30:0], 1'b1};
            end
        end
    end

    always_comb begin
        sign_a  = a_r[31] & ~op_r[0];
        sign_b  = b_r[31] & ~op_r[0];
        prod    = {acc_hi, acc_lo};
        fix_dbz = 1'b0;
        {fix_hi, fix_lo} = (sign_a ^ sign_b) ? -prod : prod;
        if (op_r[1]) begin
            if (b_r == 32'd0) begin
                fix_hi  = a_r;
                fix_lo  = 32'hFFFF_FFFF;
                fix_dbz = 1'b1;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
                fix_hi = sign_a ? -acc_hi : acc_hi;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt         <= '0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            mag_b       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_r   <= op;
            a_r    <= port_A;
            b_r    <= port_B;
            mag_b  <= mag_b_in;
            acc_hi <= '0;
            acc_lo <= mag_a_in;
        end else if (state == CALC) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
        end else if (state == FIX) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= fix_dbz;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + randomized bench for mul_div_unit against an arithmetic reference model.
// Checks cycle-exact busy/done timing, held results, reset abort and back-to-back starts.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] port_A, port_B;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          cmps = 0;
    int          errs = 0;
    logic [64:0] exp_res;

    mul_div_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op),
        .port_A(port_A), .port_B(port_B),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    // {div_by_zero, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = ua * ub; return {1'b0, p}; end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb; sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = ua / ub; ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        cmps++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one op; verifies every cycle up to done. hold keeps start high for a
    // back-to-back successor; pulse_at fires a stray DIVU start while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int pulse_at);
        logic [64:0] nres;
        nres = model(o, a, b);
        @(negedge CLK);
        RST = 1'b0; start = 1'b1; op = o; port_A = a; port_B = b;
        @(posedge CLK); #1;
        if (!hold) start = 1'b0;
        port_A = $urandom; port_B = $urandom; op = 2'($urandom_range(0, 3));
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) begin @(posedge CLK); #1; end
            if (k < 34) begin
                check("busy_calc", busy, 1);
                check("done_early", done, 0);
                check("res_held", {div_by_zero, hi, lo}, exp_res);
            end else begin
                check("done_pulse", done, 1);
                check("busy_done", busy, 0);
                check($sformatf("result op%0d %h/%h", o, a, b), {div_by_zero, hi, lo}, nres);
            end
            if (pulse_at == k) begin
                start = 1'b1; op = 2'b11; port_A = $urandom; port_B = $urandom;
            end else if (pulse_at == k - 1 && !hold) begin
                start = 1'b0;
            end
        end
        exp_res = nres;
        if (!hold) begin
            @(posedge CLK); #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_held", {div_by_zero, hi, lo}, exp_res);
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        RST = 1'b1; start = 1'b0; op = 2'b00; port_A = '0; port_B = '0;
        exp_res = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {div_by_zero, hi, lo}, 65'd0);

        // directed corner operands
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b11, 32'h0000_000A, 32'h0000_0000, 0, 0);
        run_op(2'b01, 32'h0000_0002, 32'h0000_0003, 0, 0);
        run_op(2'b10, 32'h8000_0007, 32'h0000_0000, 0, 0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);

        // stray start while busy, start held into DONE -> immediate re-accept
        run_op(2'b01, 32'd7, 32'd9, 1, 5);
        run_op(2'b11, 32'd100, 32'd7, 0, 0);

        // reset mid-divide abandons the op
        @(negedge CLK);
        start = 1'b1; op = 2'b10; port_A = 32'hFFFF_FF9C; port_B = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", {div_by_zero, hi, lo}, 65'd0);
        exp_res = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK); #1;
            check("abort_no_done", done, 0);
        end
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, 0);

        // randomized operations, some back-to-back
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = 32'($urandom);
            endcase
            run_op(ro, ra, rb, (n != 23) && ($urandom_range(0, 3) == 0), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request a new operation; sampled only when accepting (REQ-011).
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 port_A  in  32  multiplicand / dividend (register file rs operand, same source as the ALU port_A).
REQ-007 port_B  in  32  multiplier / divisor (register file rt operand, same source as the ALU port_B).
REQ-008 busy  out  1  operation in progress; new start is ignored while high.
REQ-009 done  out  1  single-cycle pulse; hi/lo hold the new result in this cycle.
REQ-010 hi, lo  out  32 each  result registers to the writeback mux; div_by_zero  out  1  flag for the last divide with port_B==0, valid with done and held after.

Function
REQ-011 States: IDLE, CALC, FIX, DONE. start is accepted at an edge where state is IDLE or DONE and start==1.
REQ-012 On acceptance, op, port_A and port_B are captured into internal registers; later input changes do not affect the operation in flight.
REQ-013 Acceptance edge E0 -> CALC with iteration counter=0.
REQ-014 CALC performs one radix-2 step per cycle on operand magnitudes (shift-add multiply, restoring divide) for 32 cycles, then moves to FIX at E32.
REQ-015 FIX applies sign correction and moves to DONE at E33, where hi, lo and div_by_zero are registered.
REQ-016 DONE lasts one cycle with done==1 and busy==0, then moves to IDLE, or to CALC if a new start is accepted (back-to-back).
REQ-017 Timing: busy==1 in CALC and FIX, i.e. the cycles after E0 through E33; busy==0 in IDLE and DONE.
REQ-018 Fixed latency: done is high in the 34th cycle after the acceptance edge for every op, including divide by zero.
REQ-019 MULTU: {hi,lo} = unsigned 64-bit product.
REQ-020 MULT: the 64-bit product of the magnitudes is two's-complement negated if the operand signs differ.
REQ-021 DIVU: lo = quotient and hi = remainder, both unsigned.
REQ-022 DIV, quotient: lo is negated if the operand signs differ (truncation toward zero).
REQ-023 DIV, remainder: hi takes the sign of the dividend; port_A = -2^31 is handled by its 32-bit unsigned magnitude 0x80000000.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no flag.
REQ-025 Divide by zero (DIV or DIVU): hi = captured port_A unchanged, lo=0xFFFFFFFF, div_by_zero=1.
REQ-026 Any multiply, or any divide with a nonzero divisor, clears div_by_zero at its E33.
REQ-027 hi, lo and div_by_zero change only at E33 or on reset; between operations they hold their values.
REQ-028 A start asserted while busy==1 is dropped, not queued; start held continuously is re-accepted at the DONE cycle.

Reset
REQ-029 RST==1 at an edge forces the state to IDLE and clears the iteration counter and internal operand registers.
REQ-030 The same reset edge sets hi=0, lo=0, div_by_zero=0, busy=0 and done=0.
REQ-031 RST has priority over start; an operation in flight is abandoned with no done pulse.
REQ-032 The first start is accepted at the first edge with RST==0.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 34 cycles after the accept edge, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 0x0000000A / 0 -> done at cycle 34, div_by_zero=1, hi=0x0000000A, lo=0xFFFFFFFF; a following MULTU 2x3 -> div_by_zero=0, lo=6.
REQ-037 Start MULTU 7x9, then pulse start with DIVU at cycle 5 and toggle port_A/port_B mid-operation -> single done, lo=63, hi=0; start held high at DONE -> second operation accepted with no idle cycle.
REQ-038 Start DIV, assert RST for one cycle at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new start after reset completes normally.
